// File: rtl/reorder_buffer_pkg.sv
// Shared sizing, types and pointer helpers for the reorder buffer.
// Entry count is a power of two so every pointer wraps by plain overflow.
package reorder_buffer_pkg;

  localparam int ROB_WIDTH_BIT = 3;
  localparam int ROB_SIZE      = 1 << ROB_WIDTH_BIT;

  typedef logic [ROB_WIDTH_BIT-1:0] rob_id_t;
  typedef logic [ROB_WIDTH_BIT:0]   rob_cnt_t;

  localparam rob_cnt_t ROB_FULL_COUNT = rob_cnt_t'(ROB_SIZE);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] value;
    logic        is_branch;
    logic        pred_taken;
    logic        actual_taken;
    logic [31:0] alt_pc;
  } rob_entry_t;

  function automatic rob_id_t rob_next(input rob_id_t id);
    return id + rob_id_t'(1);
  endfunction

endpackage

// File: rtl/rob_query_port.sv
// One operand-tag lookup into the reorder buffer.
// A result on either CDB this cycle is forwarded ahead of the stored entry.
module rob_query_port
  import reorder_buffer_pkg::*;
(
  input  logic                     enable,
  input  rob_id_t                  tag,
  input  logic [ROB_SIZE-1:0]      busy,
  input  logic [ROB_SIZE-1:0]      ready,
  input  logic [ROB_SIZE-1:0][31:0] value,
  input  logic                     alu_valid,
  input  rob_id_t                  alu_id,
  input  logic [31:0]              alu_val,
  input  logic                     lsb_valid,
  input  rob_id_t                  lsb_id,
  input  logic [31:0]              lsb_val,
  output logic                     result_ready,
  output logic [31:0]              result_val
);

  always_comb begin
    result_ready = 1'b0;
    result_val   = '0;
    if (enable) begin
      if (alu_valid && alu_id == tag) begin
        result_ready = 1'b1;
        result_val   = alu_val;
      end else if (lsb_valid && lsb_id == tag) begin
        result_ready = 1'b1;
        result_val   = lsb_val;
      end else if (busy[tag] && ready[tag]) begin
        result_ready = 1'b1;
        result_val   = value[tag];
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates ids at issue, captures two CDBs,
// answers operand queries and retires in order with mispredict flush.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic        issue_is_branch,
  input  logic        issue_pred_taken,
  input  logic [31:0] issue_alt_pc,
  output logic        rob_full,
  output rob_id_t     issue_rob_id,
  output logic [4:0]  new_reg_id,
  output rob_id_t     new_ROB_id,
  input  logic        alu_cdb_valid,
  input  rob_id_t     alu_cdb_rob_id,
  input  logic [31:0] alu_cdb_val,
  input  logic        alu_cdb_taken,
  input  logic        lsb_cdb_valid,
  input  rob_id_t     lsb_cdb_rob_id,
  input  logic [31:0] lsb_cdb_val,
  input  rob_id_t     rs1_id,
  input  rob_id_t     rs2_id,
  output logic        rs1_ready,
  output logic        rs2_ready,
  output logic [31:0] rs1_val,
  output logic [31:0] rs2_val,
  output logic [4:0]  write_reg_id,
  output rob_id_t     write_ROB_id,
  output logic [31:0] write_val,
  output logic        real_commit,
  output logic        clear_flag,
  output logic [31:0] redirect_pc
);

  rob_id_t              head;
  rob_id_t              tail;
  rob_cnt_t             count;
  logic [ROB_SIZE-1:0]  busy;
  logic [ROB_SIZE-1:0]  ready;
  rob_entry_t           entries [ROB_SIZE];
  logic [ROB_SIZE-1:0][31:0] value_vec;

  logic       alloc;
  logic       commit;
  logic       mispredict;
  rob_entry_t head_entry;

  assign head_entry = entries[head];

  // Fullness uses the registered count only; a same-cycle retire never frees a slot.
  assign rob_full = !rst_in || (count == ROB_FULL_COUNT) || clear_flag;
  assign alloc    = issue_valid && !rob_full && rdy_in;
  assign commit   = rst_in && rdy_in && !clear_flag && busy[head] && ready[head];
  assign mispredict = commit && head_entry.is_branch &&
                      (head_entry.actual_taken != head_entry.pred_taken);

  assign issue_rob_id = tail;
  assign new_ROB_id   = tail;
  assign new_reg_id   = alloc ? issue_rd : 5'd0;

  assign real_commit  = commit;
  assign write_reg_id = commit ? head_entry.rd : 5'd0;
  assign write_ROB_id = head;
  assign write_val    = commit ? head_entry.value : 32'd0;

  always_comb begin
    value_vec = '0;
    for (int i = 0; i < ROB_SIZE; i++) value_vec[i] = entries[i].value;
  end

  rob_query_port u_query_rs1 (
    .enable       (rst_in),
    .tag          (rs1_id),
    .busy         (busy),
    .ready        (ready),
    .value        (value_vec),
    .alu_valid    (alu_cdb_valid),
    .alu_id       (alu_cdb_rob_id),
    .alu_val      (alu_cdb_val),
    .lsb_valid    (lsb_cdb_valid),
    .lsb_id       (lsb_cdb_rob_id),
    .lsb_val      (lsb_cdb_val),
    .result_ready (rs1_ready),
    .result_val   (rs1_val)
  );

  rob_query_port u_query_rs2 (
    .enable       (rst_in),
    .tag          (rs2_id),
    .busy         (busy),
    .ready        (ready),
    .value        (value_vec),
    .alu_valid    (alu_cdb_valid),
    .alu_id       (alu_cdb_rob_id),
    .alu_val      (alu_cdb_val),
    .lsb_valid    (lsb_cdb_valid),
    .lsb_id       (lsb_cdb_rob_id),
    .lsb_val      (lsb_cdb_val),
    .result_ready (rs2_ready),
    .result_val   (rs2_val)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      busy        <= '0;
      ready       <= '0;
      clear_flag  <= 1'b0;
      redirect_pc <= '0;
    end else if (rdy_in) begin
      if (clear_flag) begin
        busy       <= '0;
        ready      <= '0;
        head       <= '0;
        tail       <= '0;
        count      <= '0;
        clear_flag <= 1'b0;
      end else begin
        if (alloc) begin
          busy[tail]    <= 1'b1;
          ready[tail]   <= 1'b0;
          entries[tail] <= '{rd: issue_rd, value: 32'd0, is_branch: issue_is_branch,
                             pred_taken: issue_pred_taken, actual_taken: 1'b0,
                             alt_pc: issue_alt_pc};
          tail          <= rob_next(tail);
        end
        // ALU is applied last so it wins if both CDBs ever name one entry.
        if (lsb_cdb_valid && busy[lsb_cdb_rob_id]) begin
          ready[lsb_cdb_rob_id]         <= 1'b1;
          entries[lsb_cdb_rob_id].value <= lsb_cdb_val;
        end
        if (alu_cdb_valid && busy[alu_cdb_rob_id]) begin
          ready[alu_cdb_rob_id]                <= 1'b1;
          entries[alu_cdb_rob_id].value        <= alu_cdb_val;
          entries[alu_cdb_rob_id].actual_taken <= alu_cdb_taken;
        end
        if (commit) begin
          busy[head]  <= 1'b0;
          ready[head] <= 1'b0;
          head        <= rob_next(head);
          if (mispredict) begin
            clear_flag  <= 1'b1;
            redirect_pc <= head_entry.alt_pc;
          end
        end
        unique case ({alloc, commit})
          2'b10:   count <= count + rob_cnt_t'(1);
          2'b01:   count <= count - rob_cnt_t'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized and directed bench for reorder_buffer against a queue-based
// model of in-order allocation, CDB capture, retirement and flush.
module tb_reorder_buffer;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_is_branch;
  logic        issue_pred_taken;
  logic [31:0] issue_alt_pc;
  logic        rob_full;
  logic [2:0]  issue_rob_id;
  logic [4:0]  new_reg_id;
  logic [2:0]  new_ROB_id;
  logic        alu_cdb_valid;
  logic [2:0]  alu_cdb_rob_id;
  logic [31:0] alu_cdb_val;
  logic        alu_cdb_taken;
  logic        lsb_cdb_valid;
  logic [2:0]  lsb_cdb_rob_id;
  logic [31:0] lsb_cdb_val;
  logic [2:0]  rs1_id, rs2_id;
  logic        rs1_ready, rs2_ready;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  write_reg_id;
  logic [2:0]  write_ROB_id;
  logic [31:0] write_val;
  logic        real_commit;
  logic        clear_flag;
  logic [31:0] redirect_pc;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_branch(issue_is_branch),
    .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
    .rob_full(rob_full), .issue_rob_id(issue_rob_id), .new_reg_id(new_reg_id),
    .new_ROB_id(new_ROB_id),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob_id(alu_cdb_rob_id),
    .alu_cdb_val(alu_cdb_val), .alu_cdb_taken(alu_cdb_taken),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob_id(lsb_cdb_rob_id), .lsb_cdb_val(lsb_cdb_val),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .write_reg_id(write_reg_id), .write_ROB_id(write_ROB_id), .write_val(write_val),
    .real_commit(real_commit), .clear_flag(clear_flag), .redirect_pc(redirect_pc)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: live instructions in program order, each tagged with its id.
  typedef struct {
    int          id;
    logic [4:0]  rd;
    bit          rdy;
    logic [31:0] val;
    bit          br;
    bit          pred;
    bit          act;
    logic [31:0] alt;
  } ment_t;

  ment_t       q[$];
  int          m_tail = 0;
  bit          m_flush = 0;
  logic [31:0] m_redirect = 0;
  bit          m_alloc, m_com;

  function automatic void model_query(input logic [2:0] id, output bit r, output logic [31:0] v);
    r = 0; v = 0;
    if (alu_cdb_valid && alu_cdb_rob_id == id) begin r = 1; v = alu_cdb_val; end
    else if (lsb_cdb_valid && lsb_cdb_rob_id == id) begin r = 1; v = lsb_cdb_val; end
    else foreach (q[i]) if (q[i].id == int'(id) && q[i].rdy) begin r = 1; v = q[i].val; end
  endfunction

  function automatic bit names_ready(input logic [2:0] id);
    foreach (q[i]) if (q[i].id == int'(id) && q[i].rdy) return 1;
    return 0;
  endfunction

  task automatic prep();
    @(negedge clk_in);
    rst_in = 1; rdy_in = 1;
    issue_valid = 0; issue_rd = 0; issue_is_branch = 0; issue_pred_taken = 0; issue_alt_pc = 0;
    alu_cdb_valid = 0; alu_cdb_rob_id = 0; alu_cdb_val = 0; alu_cdb_taken = 0;
    lsb_cdb_valid = 0; lsb_cdb_rob_id = 0; lsb_cdb_val = 0;
    rs1_id = 0; rs2_id = 0;
  endtask

  task automatic eval();
    bit full, r;
    logic [31:0] v;
    #1;
    if (!rst_in) begin
      m_alloc = 0; m_com = 0;
      expect_eq("rst_rob_full", rob_full, 1);
      expect_eq("rst_new_reg_id", new_reg_id, 0);
      expect_eq("rst_write_reg_id", write_reg_id, 0);
      expect_eq("rst_real_commit", real_commit, 0);
      expect_eq("rst_rs1_ready", rs1_ready, 0);
      expect_eq("rst_rs2_ready", rs2_ready, 0);
      expect_eq("rst_rs1_val", rs1_val, 0);
      expect_eq("rst_rs2_val", rs2_val, 0);
      return;
    end
    full    = (q.size() == 8) || m_flush;
    m_alloc = issue_valid && !full && rdy_in;
    m_com   = rdy_in && !m_flush && q.size() > 0 && q[0].rdy;
    expect_eq("rob_full", rob_full, full);
    expect_eq("new_reg_id", new_reg_id, m_alloc ? issue_rd : 5'd0);
    expect_eq("new_ROB_id", new_ROB_id, m_tail);
    expect_eq("issue_rob_id", issue_rob_id, m_tail);
    expect_eq("real_commit", real_commit, m_com);
    expect_eq("write_reg_id", write_reg_id, m_com ? q[0].rd : 5'd0);
    if (m_com) begin
      expect_eq("write_ROB_id", write_ROB_id, q[0].id);
      expect_eq("write_val", write_val, q[0].val);
    end
    expect_eq("clear_flag", clear_flag, m_flush);
    if (m_flush) expect_eq("redirect_pc", redirect_pc, m_redirect);
    model_query(rs1_id, r, v);
    expect_eq("rs1_ready", rs1_ready, r);
    if (r) expect_eq("rs1_val", rs1_val, v);
    model_query(rs2_id, r, v);
    expect_eq("rs2_ready", rs2_ready, r);
    if (r) expect_eq("rs2_val", rs2_val, v);
  endtask

  task automatic fin();
    ment_t e;
    @(posedge clk_in);
    if (!rst_in) begin
      q.delete(); m_tail = 0; m_flush = 0; m_redirect = 0;
    end else if (rdy_in) begin
      if (m_flush) begin
        q.delete(); m_tail = 0; m_flush = 0;
      end else begin
        foreach (q[i]) begin
          e = q[i];
          if (lsb_cdb_valid && e.id == int'(lsb_cdb_rob_id)) begin e.rdy = 1; e.val = lsb_cdb_val; end
          if (alu_cdb_valid && e.id == int'(alu_cdb_rob_id)) begin
            e.rdy = 1; e.val = alu_cdb_val; e.act = alu_cdb_taken;
          end
          q[i] = e;
        end
        if (m_com) begin
          e = q.pop_front();
          if (e.br && e.act != e.pred) begin m_flush = 1; m_redirect = e.alt; end
        end
        if (m_alloc) begin
          e = '{id: m_tail, rd: issue_rd, rdy: 0, val: 0, br: issue_is_branch,
                pred: issue_pred_taken, act: 0, alt: issue_alt_pc};
          q.push_back(e);
          m_tail = (m_tail + 1) % 8;
        end
      end
    end
  endtask

  task automatic do_reset();
    prep(); rst_in = 0; eval(); fin();
  endtask

  task automatic do_issue(input logic [4:0] rd);
    prep(); issue_valid = 1; issue_rd = rd; eval(); fin();
  endtask

  function automatic logic [2:0] pick_id();
    if (q.size() > 0 && $urandom_range(3) != 0) return 3'(q[$urandom_range(q.size() - 1)].id);
    return 3'($urandom_range(7));
  endfunction

  initial begin
    rst_in = 0; rdy_in = 0; issue_valid = 0; issue_rd = 0; issue_is_branch = 0;
    issue_pred_taken = 0; issue_alt_pc = 0; alu_cdb_valid = 0; alu_cdb_rob_id = 0;
    alu_cdb_val = 0; alu_cdb_taken = 0; lsb_cdb_valid = 0; lsb_cdb_rob_id = 0;
    lsb_cdb_val = 0; rs1_id = 0; rs2_id = 0;

    // Issue, query, forward, commit
    do_reset();
    prep(); issue_valid = 1; issue_rd = 5; eval();
    expect_eq("t1_new_reg_id", new_reg_id, 5);
    expect_eq("t1_new_ROB_id", new_ROB_id, 0);
    fin();
    prep(); rs1_id = 0; eval(); expect_eq("t1_rs1_unready", rs1_ready, 0); fin();
    prep(); rs1_id = 0; alu_cdb_valid = 1; alu_cdb_rob_id = 0; alu_cdb_val = 32'h1234; eval();
    expect_eq("t2_fwd_ready", rs1_ready, 1);
    expect_eq("t2_fwd_val", rs1_val, 32'h1234);
    expect_eq("t2_no_same_cycle_commit", real_commit, 0);
    fin();
    prep(); eval();
    expect_eq("t2_commit", real_commit, 1);
    expect_eq("t2_commit_rd", write_reg_id, 5);
    expect_eq("t2_commit_val", write_val, 32'h1234);
    fin();

    // Fill, overflow attempt, out-of-order completion
    do_reset();
    for (int i = 0; i < 8; i++) do_issue(5'(i + 1));
    prep(); issue_valid = 1; issue_rd = 9; eval();
    expect_eq("t3_full", rob_full, 1);
    expect_eq("t3_blocked_rename", new_reg_id, 0);
    fin();
    prep(); alu_cdb_valid = 1; alu_cdb_rob_id = 2; alu_cdb_val = 32'h22; eval();
    expect_eq("t3_tail_stays", new_ROB_id, 0);
    expect_eq("t4_no_commit_2", real_commit, 0);
    fin();
    prep(); alu_cdb_valid = 1; alu_cdb_rob_id = 0; alu_cdb_val = 32'h00; eval();
    expect_eq("t4_no_commit_0", real_commit, 0);
    fin();
    prep(); lsb_cdb_valid = 1; lsb_cdb_rob_id = 1; lsb_cdb_val = 32'h11; eval();
    expect_eq("t4_retire_id0", write_ROB_id, 0); fin();
    prep(); eval(); expect_eq("t4_retire_id1", write_ROB_id, 1); fin();
    prep(); eval(); expect_eq("t4_retire_id2", write_ROB_id, 2);
    expect_eq("t4_retire_val2", write_val, 32'h22); fin();

    // Mispredicted branch with younger entries live
    do_reset();
    prep(); issue_valid = 1; issue_rd = 3; issue_is_branch = 1; issue_pred_taken = 0;
    issue_alt_pc = 32'h100; eval(); fin();
    do_issue(4);
    do_issue(6);
    prep(); alu_cdb_valid = 1; alu_cdb_rob_id = 0; alu_cdb_val = 7; alu_cdb_taken = 1; eval(); fin();
    prep(); eval();
    expect_eq("t5_branch_commit_rd", write_reg_id, 3);
    expect_eq("t5_no_flush_yet", clear_flag, 0);
    fin();
    prep(); issue_valid = 1; issue_rd = 8; eval();
    expect_eq("t5_clear_flag", clear_flag, 1);
    expect_eq("t5_redirect_pc", redirect_pc, 32'h100);
    expect_eq("t5_flush_no_alloc", new_reg_id, 0);
    expect_eq("t5_flush_no_commit", real_commit, 0);
    fin();
    prep(); issue_valid = 1; issue_rd = 8; rs1_id = 1; eval();
    expect_eq("t5_flag_pulse", clear_flag, 0);
    expect_eq("t5_tail_zero", new_ROB_id, 0);
    expect_eq("t5_younger_gone", rs1_ready, 0);
    fin();

    // rdy_in stall with ready head
    do_reset();
    do_issue(9);
    prep(); alu_cdb_valid = 1; alu_cdb_rob_id = 0; alu_cdb_val = 32'habc; eval(); fin();
    for (int i = 0; i < 3; i++) begin
      prep(); rdy_in = 0; issue_valid = 1; issue_rd = 2; eval();
      expect_eq("t6_stall_commit", real_commit, 0);
      expect_eq("t6_stall_rename", new_reg_id, 0);
      fin();
    end
    prep(); issue_valid = 1; issue_rd = 2; eval();
    expect_eq("t6_resume_commit", real_commit, 1);
    expect_eq("t6_resume_val", write_val, 32'habc);
    expect_eq("t6_resume_tail", new_ROB_id, 1);
    fin();

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      prep();
      rst_in = ($urandom_range(199) != 0);
      rdy_in = ($urandom_range(9) != 0);
      issue_valid = ($urandom_range(9) < 6);
      issue_rd = 5'($urandom_range(31));
      issue_is_branch = $urandom_range(1);
      issue_pred_taken = $urandom_range(1);
      issue_alt_pc = $urandom;
      alu_cdb_valid = ($urandom_range(1) == 1);
      alu_cdb_rob_id = pick_id();
      alu_cdb_val = $urandom;
      alu_cdb_taken = $urandom_range(1);
      lsb_cdb_valid = ($urandom_range(2) == 0);
      lsb_cdb_rob_id = pick_id();
      lsb_cdb_val = $urandom;
      if (names_ready(alu_cdb_rob_id)) alu_cdb_valid = 0;
      if (names_ready(lsb_cdb_rob_id) || (alu_cdb_valid && lsb_cdb_rob_id == alu_cdb_rob_id))
        lsb_cdb_valid = 0;
      rs1_id = pick_id();
      rs2_id = pick_id();
      eval();
      fin();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
